// File: rtl/sp_request_engine_if.sv
// sp_request_engine_if: request, DRAM, scratchpad and systolic-array signals of the request engine
interface sp_request_engine_if #(parameter int ROW_W = 64);
  logic sp_write;
  logic [1:0] req_type;
  logic [3:0] req_md, req_ms1, req_ms2, req_ms3;
  logic [31:0] req_addr;
  logic req_full, req_overflow, busy;
  logic dram_ren, dram_wen, dram_ready;
  logic [31:0] dram_addr;
  logic [ROW_W-1:0] dram_wdata, dram_rdata;
  logic sp_wen, sp_ren;
  logic [3:0] sp_sel;
  logic [1:0] sp_row;
  logic [ROW_W-1:0] sp_wdata, sp_rdata;
  logic sa_valid, sa_ready, sa_done;
  logic [3:0] sa_md, sa_ms1, sa_ms2, sa_ms3;
  logic load_complete, store_complete, gemm_complete;
  logic [3:0] complete_md;
  modport slave (
    input sp_write, req_type, req_md, req_ms1, req_ms2, req_ms3, req_addr,
    input dram_rdata, dram_ready, sp_rdata, sa_ready, sa_done,
    output req_full, req_overflow, busy, dram_ren, dram_wen, dram_addr, dram_wdata,
    output sp_wen, sp_ren, sp_sel, sp_row, sp_wdata, sa_valid, sa_md, sa_ms1, sa_ms2, sa_ms3,
    output load_complete, store_complete, gemm_complete, complete_md
  );
  modport master (
    output sp_write, req_type, req_md, req_ms1, req_ms2, req_ms3, req_addr,
    output dram_rdata, dram_ready, sp_rdata, sa_ready, sa_done,
    input req_full, req_overflow, busy, dram_ren, dram_wen, dram_addr, dram_wdata,
    input sp_wen, sp_ren, sp_sel, sp_row, sp_wdata, sa_valid, sa_md, sa_ms1, sa_ms2, sa_ms3,
    input load_complete, store_complete, gemm_complete, complete_md
  );
endinterface

// File: rtl/sp_request_engine.sv
// sp_request_engine: queues load/store/gemm requests and sequences them one at a time over DRAM, scratchpad and systolic array
module sp_request_engine #(
  parameter int FIFO_DEPTH = 4,
  parameter int ROWS = 4,
  parameter int ROW_W = 64
) (
  input logic clk,
  input logic rst,
  sp_request_engine_if.slave bus
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] DEPTH = FIFO_DEPTH;
  typedef struct packed {
    logic [1:0] typ;
    logic [3:0] md, ms1, ms2, ms3;
    logic [31:0] addr;
  } req_t;
  typedef enum logic [2:0] {IDLE, LD, ST_RD, ST_WR, GM_ISSUE, GM_WAIT, DONE} state_t;
  state_t state_q, state_d;
  req_t fifo_q [FIFO_DEPTH];
  req_t cur_q, cur_d, head;
  logic [AW-1:0] wp_q, rp_q;
  logic [AW:0] cnt_q;
  logic [1:0] row_q, row_d;
  logic [ROW_W-1:0] wd_q;
  logic rd_pend_q, ovf_q;
  logic req_v, full, push, pop, last, ld, st_rd, st_wr, sa_v, done;
  logic [31:0] row_addr;
  assign req_v = bus.sp_write && bus.req_type != 2'b00;
  assign full = cnt_q == DEPTH;
  assign push = req_v && !full;
  assign pop = state_q == IDLE && cnt_q != '0;
  assign head = fifo_q[rp_q];
  assign last = row_q == 2'(ROWS - 1);
  assign row_addr = cur_q.addr + {27'd0, row_q, 3'd0};
  always_ff @(posedge clk)
    if (push) fifo_q[wp_q] <= {bus.req_type, bus.req_md, bus.req_ms1, bus.req_ms2, bus.req_ms3, bus.req_addr};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      cur_q <= '0;
      wp_q <= '0;
      rp_q <= '0;
      cnt_q <= '0;
      row_q <= '0;
      wd_q <= '0;
      rd_pend_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q <= cur_d;
      row_q <= row_d;
      wp_q <= wp_q + AW'(push);
      rp_q <= rp_q + AW'(pop);
      cnt_q <= cnt_q + (AW+1)'(push) - (AW+1)'(pop);
      rd_pend_q <= st_rd;
      if (rd_pend_q) wd_q <= bus.sp_rdata;
      if (req_v && full) ovf_q <= 1'b1;
    end
  always_comb begin
    state_d = state_q;
    cur_d = cur_q;
    row_d = row_q;
    case (state_q)
      IDLE: if (pop) begin
        cur_d = head;
        row_d = '0;
        state_d = head.typ == 2'b01 ? LD : head.typ == 2'b10 ? ST_RD : GM_ISSUE;
      end
      LD: if (bus.dram_ready) begin
        row_d = row_q + 2'd1;
        state_d = last ? DONE : LD;
      end
      ST_RD: state_d = ST_WR;
      ST_WR: if (bus.dram_ready) begin
        row_d = row_q + 2'd1;
        state_d = last ? DONE : ST_RD;
      end
      GM_ISSUE: state_d = bus.sa_ready ? GM_WAIT : GM_ISSUE;
      GM_WAIT: state_d = bus.sa_done ? DONE : GM_WAIT;
      default: state_d = IDLE;
    endcase
  end
  assign ld = state_q == LD;
  assign st_rd = state_q == ST_RD;
  assign st_wr = state_q == ST_WR;
  assign sa_v = state_q == GM_ISSUE;
  assign done = state_q == DONE;
  assign bus.req_full = full;
  assign bus.req_overflow = ovf_q;
  assign bus.busy = state_q != IDLE || cnt_q != '0;
  assign bus.dram_ren = ld;
  assign bus.dram_wen = st_wr;
  assign bus.dram_addr = ld || st_wr ? row_addr : '0;
  // the first ST_WR cycle forwards the scratchpad data before it lands in wd_q
  assign bus.dram_wdata = !st_wr ? '0 : rd_pend_q ? bus.sp_rdata : wd_q;
  assign bus.sp_wen = ld && bus.dram_ready;
  assign bus.sp_ren = st_rd;
  assign bus.sp_sel = bus.sp_wen || st_rd ? cur_q.md : '0;
  assign bus.sp_row = bus.sp_wen || st_rd ? row_q : '0;
  assign bus.sp_wdata = bus.sp_wen ? bus.dram_rdata : '0;
  assign bus.sa_valid = sa_v;
  assign bus.sa_md = sa_v ? cur_q.md : '0;
  assign bus.sa_ms1 = sa_v ? cur_q.ms1 : '0;
  assign bus.sa_ms2 = sa_v ? cur_q.ms2 : '0;
  assign bus.sa_ms3 = sa_v ? cur_q.ms3 : '0;
  assign bus.load_complete = done && cur_q.typ == 2'b01;
  assign bus.store_complete = done && cur_q.typ == 2'b10;
  assign bus.gemm_complete = done && cur_q.typ == 2'b11;
  assign bus.complete_md = done ? cur_q.md : '0;
endmodule

// File: doc/sp_request_engine.md
SP_REQUEST_ENGINE -- requirements
Module: sp_request_engine

Interface
REQ-001 Parameter FIFO_DEPTH, 4, request FIFO entries (power of two).
REQ-002 Parameter ROWS, 4, rows per matrix transfer.
REQ-003 Parameter ROW_W, 64, bits per matrix row (4 x 16-bit elements).
REQ-004 CLK  in  1  sole clock, rising edge.
REQ-005 RST  in  1  reset, asynchronous, active-high.
REQ-006 sp_write  in  1  request push strobe from execute.
REQ-007 req_type  in  2  01 matrix load, 10 matrix store, 11 gemm, 00 none.
REQ-008 req_md  in  4  destination / store-source matrix register.
REQ-009 req_ms1, req_ms2, req_ms3  in  4 each  gemm source matrix registers.
REQ-010 req_addr  in  32  byte base address for load/store.
REQ-011 req_full  out  1  FIFO full.
REQ-012 req_overflow  out  1  sticky: push attempted while full.
REQ-013 busy  out  1  FSM not IDLE or FIFO not empty.
REQ-014 dram_ren, dram_wen  out  1 each  memory read/write request.
REQ-015 dram_addr  out  32;  dram_wdata  out  ROW_W;  dram_rdata  in  ROW_W;  dram_ready  in  1  (transfer completes in the cycle ready=1).
REQ-016 sp_wen  out  1;  sp_ren  out  1;  sp_sel  out  4;  sp_row  out  2;  sp_wdata  out  ROW_W;  sp_rdata  in  ROW_W (valid cycle after sp_ren).
REQ-017 sa_valid  out  1;  sa_ready  in  1;  sa_md, sa_ms1, sa_ms2, sa_ms3  out  4 each;  sa_done  in  1  (systolic array issue/complete).
REQ-018 load_complete, store_complete, gemm_complete  out  1 each  one-cycle pulses;  complete_md  out  4  matrix register of the completed request.

Function
REQ-019 Push when sp_write=1, req_type!=00 and req_full=0; fields stored {type, md, ms1..3, addr}.
REQ-020 Push with req_type=00 is ignored; push while full is dropped and sets req_overflow.
REQ-021 req_full derived from registered count; pop in the same cycle does not admit a push at full.
REQ-022 Pointers wrap modulo FIFO_DEPTH; count range 0..FIFO_DEPTH.
REQ-023 States: IDLE, LD, ST_RD, ST_WR, GM_ISSUE, GM_WAIT, DONE.
REQ-024 IDLE: if FIFO non-empty, pop head into working registers, row=0, go to LD / ST_RD / GM_ISSUE by type; earliest dispatch is the cycle after push.
REQ-025 LD: dram_ren=1, dram_addr=addr+8*row; when dram_ready=1, same cycle sp_wen=1, sp_sel=md, sp_row=row, sp_wdata=dram_rdata; row increments; after row ROWS-1 go DONE.
REQ-026 ST_RD: sp_ren=1, sp_sel=md, sp_row=row for one cycle, then ST_WR.
REQ-027 ST_WR: dram_wen=1, dram_addr=addr+8*row, dram_wdata=sp_rdata captured one cycle after sp_ren and held until dram_ready; on ready, row increments, go ST_RD, or DONE after row ROWS-1.
REQ-028 GM_ISSUE: sa_valid=1 with md/ms1..3 held stable until sa_ready=1, then GM_WAIT; GM_WAIT holds until sa_done=1, then DONE.
REQ-029 DONE: exactly one of load_complete/store_complete/gemm_complete pulses for one cycle per type, complete_md=md; next state IDLE.
REQ-030 Address arithmetic 32-bit modulo 2^32; wrap silently.
REQ-031 dram_ren and dram_wen never asserted together; memory ports idle outside LD/ST_WR.
REQ-032 sa_done outside GM_WAIT and dram_ready outside LD/ST_WR are ignored.
REQ-033 Requests complete strictly in FIFO order; one request in flight.
REQ-034 Pushes accepted in every state, including while a request is in flight.

Reset
REQ-035 RST=1 asynchronously forces IDLE, empties FIFO, clears row, working registers and req_overflow.
REQ-036 During reset all outputs 0, including mid-transfer; the in-flight request is discarded with no completion pulse.

Verification
REQ-037 Load md=3 addr=0x100, dram_ready=1 always -> dram_addr 0x100,0x108,0x110,0x118 on consecutive cycles, sp_wen x4 rows 0-3, load_complete=1 complete_md=3 one cycle later.
REQ-038 Store md=5 addr=0x200, dram_ready after 2 wait cycles per row -> 4 ST_RD/ST_WR pairs, dram_wdata equals sp_rdata per row, store_complete=1 with complete_md=5.
REQ-039 Gemm md=2 ms1=0 ms2=1 ms3=4, sa_ready delayed 3 cycles, sa_done 10 cycles later -> sa_valid held 4 cycles with stable fields, one gemm_complete pulse after sa_done.
REQ-040 Five pushes back-to-back while FSM stalled (dram_ready=0) -> req_full=1 after fourth, fifth dropped, req_overflow=1; four completions in push order.
REQ-041 RST pulse during LD row 2 -> outputs 0 immediately, FIFO empty, busy=0, no load_complete; subsequent load executes normally.
REQ-042 addr=0xFFFFFFF8 load -> dram_addr 0xFFFFFFF8, 0x00000000, 0x00000008, 0x00000010.
